// File: rtl/pattern_stream_gen.sv
// Serial pattern generator: captures a parallel pattern and streams it MSB-first on d_out.
// Optional even-parity trailer bit when PATTERN_STREAM_GEN_PARITY_EN is defined.
module pattern_stream_gen #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 6
) (
    input  logic             slowed_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             loop_en,
    input  logic             abort,
    output logic             d_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2
`ifdef PATTERN_STREAM_GEN_PARITY_EN
        ,PARITY = 2'd3
`endif
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
`ifdef PATTERN_STREAM_GEN_PARITY_EN
    localparam logic [IDX_W-1:0] PAR_IDX  = IDX_W'(WIDTH);
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] frame_copy;
    logic             frame_end;

    // The loop/DONE decision is taken on whichever cycle carries the last bit of the frame.
    always_comb begin
        frame_end = 1'b0;
`ifdef PATTERN_STREAM_GEN_PARITY_EN
        frame_end = (state == PARITY);
`else
        frame_end = (state == SHIFT) && (bit_idx == LAST_IDX);
`endif
    end

    always_ff @(posedge slowed_clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            frame_copy <= '0;
            d_out      <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_idx    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                d_out     <= 1'b0;
                bit_valid <= 1'b0;
                busy      <= 1'b0;
                bit_idx   <= '0;
            end else if (frame_end) begin
                frame_done <= 1'b1;
                if (loop_en) begin
                    state     <= SHIFT;
                    shreg     <= frame_copy;
                    d_out     <= frame_copy[WIDTH-1];
                    bit_idx   <= '0;
                    bit_valid <= 1'b1;
                    busy      <= 1'b1;
                end else begin
                    state     <= DONE;
                    d_out     <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    bit_idx   <= '0;
                end
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state      <= SHIFT;
                            shreg      <= pattern;
                            frame_copy <= pattern;
                            d_out      <= pattern[WIDTH-1];
                            bit_idx    <= '0;
                            bit_valid  <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    SHIFT: begin
`ifdef PATTERN_STREAM_GEN_PARITY_EN
                        if (bit_idx == LAST_IDX) begin
                            state   <= PARITY;
                            d_out   <= ^frame_copy;
                            bit_idx <= PAR_IDX;
                        end else
`endif
                        begin
                            shreg   <= shreg << 1;
                            d_out   <= shreg[WIDTH-2];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        d_out     <= 1'b0;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        bit_idx   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Self-checking bench for pattern_stream_gen (WIDTH=8): spec vectors, corner sequences, random vs model.
module tb_pattern_stream_gen;

    localparam int W  = 8;
    localparam int IW = 6;
`ifdef PATTERN_STREAM_GEN_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          loop_en = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic          d_out, bit_valid, busy, frame_done;
    logic [IW-1:0] bit_idx;
    logic [9:0]    dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: frame value plus position within the frame (-1 = not streaming).
    logic [W-1:0] m_frame = '0;
    int           m_pos = -1;
    logic         m_fd = 1'b0;

    pattern_stream_gen #(.WIDTH(W), .IDX_W(IW)) dut (
        .slowed_clk(clk),
        .reset(reset),
        .start(start),
        .pattern(pattern),
        .loop_en(loop_en),
        .abort(abort),
        .d_out(d_out),
        .bit_valid(bit_valid),
        .busy(busy),
        .frame_done(frame_done),
        .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    assign dut_vec = {d_out, bit_valid, busy, frame_done, bit_idx};

    function automatic logic [9:0] model_vec(input logic [W-1:0] fr, input int pos, input logic fd);
        logic b;
        if (pos < 0) return {3'b000, fd, 6'd0};
        b = (pos < W) ? fr[W-1-pos] : ^fr;
        return {b, 1'b1, 1'b1, fd, 6'(pos)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic l,
                        input logic [W-1:0] p, input string name);
        reset = r; start = s; abort = a; loop_en = l; pattern = p;
        @(posedge clk);
        #1;
        m_fd = 1'b0;
        if (r || a) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            if (m_pos < FB - 1) m_pos++;
            else begin
                m_fd  = 1'b1;
                m_pos = l ? 0 : -1;
            end
        end else if (s) begin
            m_frame = p;
            m_pos   = 0;
        end
        check(name, dut_vec, model_vec(m_frame, m_pos, m_fd));
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] p;
        logic [9:0]   exp;
    } vec_t;

    vec_t         tbl [11];
    logic [7:0]   sf_bits;
    logic [15:0]  bits;
    int           nbits;

    initial begin
        step(1, 0, 0, 0, '0, "reset0");
        step(1, 1, 0, 1, 8'hFF, "reset1");
        check("reset_state", dut_vec, 10'd0);

        // Single frame table
        sf_bits = 8'b0101_1010;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{(i == 0), 8'h5A, {sf_bits[7-i], 3'b110, 6'(i)}};
`ifdef PATTERN_STREAM_GEN_PARITY_EN
        tbl[8] = '{1'b0, 8'h5A, {1'b0, 3'b110, 6'd8}};
        tbl[9] = '{1'b0, 8'h5A, {4'b0001, 6'd0}};
`else
        tbl[8] = '{1'b0, 8'h5A, {4'b0001, 6'd0}};
        tbl[9] = '{1'b0, 8'h5A, 10'd0};
`endif
        tbl[10] = '{1'b0, 8'h5A, 10'd0};
        for (int i = 0; i < 11; i++) begin
            step(0, tbl[i].s, 0, 0, tbl[i].p, "single_model");
            check("single_tbl", dut_vec, tbl[i].exp);
        end

        // Looped frame: loop_en held through the first frame end, dropped for the second
        bits = '0; nbits = 0;
        for (int k = 1; k <= 2 * FB + 1; k++) begin
            step(0, (k == 1), 0, (k <= FB + 1), 8'hA5, "loop_model");
            if (bit_valid && bit_idx < IW'(W)) begin
                bits = {bits[14:0], d_out};
                nbits++;
            end
            if (k == FB + 1) check("loop_fd_bit", {frame_done, d_out, bit_idx}, {1'b1, 1'b1, 6'd0});
            if (k == 2 * FB + 1) check("loop_end", {frame_done, busy}, 2'b10);
        end
        check("loop_bits", bits, 16'hA5A5);
        check("loop_count", nbits, 16);
        step(0, 0, 0, 0, '0, "loop_idle");

        // Abort at bit_idx 3, with start and loop_en also high
        step(0, 1, 0, 0, 8'hFF, "abort_model");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 8'hFF, "abort_model");
        check("abort_pre_idx", bit_idx, 3);
        step(0, 1, 1, 1, 8'hFF, "abort_model");
        check("abort_out", dut_vec, 10'd0);
        step(0, 0, 0, 0, 8'hFF, "abort_model");
        check("abort_no_fd", dut_vec, 10'd0);
        step(0, 1, 1, 0, 8'hFF, "start_abort_model");
        check("start_abort_idle", dut_vec, 10'd0);
        step(0, 0, 0, 0, '0, "start_abort_model");

        // Reset mid-frame at bit_idx 5 while looping
        step(0, 1, 0, 1, 8'hC6, "rst_model");
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'hC6, "rst_model");
        check("rst_pre_idx", bit_idx, 5);
        step(1, 0, 0, 1, 8'hC6, "rst_model");
        check("rst_out", dut_vec, 10'd0);
        step(0, 1, 0, 0, 8'h96, "rst_model");
        check("rst_restart", {d_out, bit_valid, bit_idx}, {1'b1, 1'b1, 6'd0});
        for (int k = 0; k < FB + 1; k++) step(0, 0, 0, 0, '0, "rst_model");

        // Pattern and start changes mid-frame are ignored
        bits = '0;
        step(0, 1, 0, 0, 8'hC3, "ign_model");
        bits = {bits[14:0], d_out};
        for (int k = 1; k < W; k++) begin
            step(0, 1, 0, 0, W'($urandom), "ign_model");
            bits = {bits[14:0], d_out};
        end
        check("ign_bits", bits[7:0], 8'hC3);
        for (int k = 0; k < FB - W + 2; k++) step(0, 0, 0, 0, '0, "ign_model");

        // start held high: one DONE gap between frames
        for (int k = 1; k <= 2 * FB + 2; k++) begin
            step(0, 1, 0, 0, 8'h81, "hold_model");
            if (k == FB + 1) check("hold_gap", {frame_done, busy, bit_valid}, 3'b100);
            if (k == FB + 2) check("hold_restart", {busy, d_out, bit_idx}, {1'b1, 1'b1, 6'd0});
            if (k == 2 * FB + 2) check("hold_fd2", {frame_done, busy}, 2'b10);
        end
        step(0, 0, 0, 0, '0, "hold_model");
        step(0, 0, 0, 0, '0, "hold_model");

`ifdef PATTERN_STREAM_GEN_PARITY_EN
        step(0, 1, 0, 0, 8'h07, "par_model");
        for (int k = 2; k <= 10; k++) begin
            step(0, 0, 0, 0, 8'h07, "par_model");
            if (k == 9) check("par_bit", {d_out, bit_valid, busy, bit_idx}, {3'b111, 6'd8});
            if (k == 10) check("par_fd", {frame_done, busy}, 2'b10);
        end
        step(0, 0, 0, 0, '0, "par_model");
`endif

        // Randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 W'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
